// File: rtl/seq_alu.sv
// seq_alu: registered, WIDTH-generic ALU with valid/ready handshakes on the
// operand and result sides. Logic, arithmetic, shift and compare ops finish
// in one cycle. Multiply and unsigned divide/remainder are iterative and
// process one bit per cycle.
//
// Optional feature macro: SEQ_ALU_MULDIV_EN
//   defined     -> ops 10..12 (mul, divu, remu) use the iterative datapath
//   not defined -> ops 10..12 are illegal (result 0, err=1, one cycle); the
//                  BUSY state, bit counter and mul/div datapath are absent
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake; transfer when both are high
//   a, b, op_code       operands and operation select, captured at transfer
//   out_valid, out_ready result handshake; transfer when both are high
//   result              registered result
//   zero, ovf, err      result==0, signed add/sub overflow, illegal op or /0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no result pending, ready for an op
// BUSY  | iterative mul/div in progress (only with SEQ_ALU_MULDIV_EN)
// DONE  | result valid; may retire and accept the next op on one edge

module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("seq_alu: WIDTH must be a power of 2 and at least 4");
  end

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_MAXU = 4'd7;
  localparam logic [3:0] OP_MINU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
`ifdef SEQ_ALU_MULDIV_EN
    S_BUSY = 2'd2,
`endif
    S_IDLE = 2'd0,
    S_DONE = 2'd1
  } state_t;

  state_t state_q, state_d, accept_state;
  logic   accept;

  // Single-cycle result computed straight from the inputs at accept time
  logic [WIDTH-1:0] sc_res, sc_sum, sc_dif;
  logic             sc_ovf, sc_err, sc_multi;
  logic [SH_W-1:0]  shamt;

  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    sc_multi = 1'b0;
    shamt    = b[SH_W-1:0];
    sc_sum   = a + b;
    sc_dif   = a - b;
    case (op_code)
      OP_ADD: begin
        sc_res = sc_sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sc_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sc_dif;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sc_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      OP_MAXU: sc_res = (a > b) ? a : b;
      OP_MINU: sc_res = (a < b) ? a : b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL, OP_DIVU, OP_REMU: sc_multi = 1'b1;
`endif
      default: sc_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Iterative datapath. Mul: acc += x when y[0]; x <<= 1; y >>= 1.
  // Div: x holds the dividend, shifting quotient bits in from the right;
  // acc is the partial remainder, y the divisor. A zero divisor falls out
  // naturally as quotient all ones and remainder equal to the dividend.
  logic [3:0]       op_q;
  logic [SH_W-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_nxt, x_nxt, y_nxt, mul_sum, mc_res;
  logic [WIDTH:0]   rem_sh, rem_dif;
  logic             div0;

  always_comb begin
    rem_sh  = {acc_q, x_q[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, y_q};
    mul_sum = acc_q + (y_q[0] ? x_q : '0);
    acc_nxt = acc_q;
    x_nxt   = x_q;
    y_nxt   = y_q;
    if (op_q == OP_MUL) begin
      acc_nxt = mul_sum;
      x_nxt   = x_q << 1;
      y_nxt   = y_q >> 1;
    end else if (!rem_dif[WIDTH]) begin
      // rem_sh >= divisor, so the difference is below 2^WIDTH
      acc_nxt = rem_dif[WIDTH-1:0];
      x_nxt   = {x_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = rem_sh[WIDTH-1:0];
      x_nxt   = {x_q[WIDTH-2:0], 1'b0};
    end
    mc_res = (op_q == OP_DIVU) ? x_nxt : acc_nxt;
    div0   = (op_q != OP_MUL) && (y_q == '0);
  end

  always_comb accept_state = sc_multi ? S_BUSY : S_DONE;
`else
  always_comb accept_state = S_DONE;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = accept_state;
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_BUSY: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept  = 1'b1;
            state_d = accept_state;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      op_q   <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
`endif
    end else begin
      if (accept && !sc_multi) begin
        result <= sc_res;
        zero   <= (sc_res == '0);
        ovf    <= sc_ovf;
        err    <= sc_err;
      end
`ifdef SEQ_ALU_MULDIV_EN
      if (accept && sc_multi) begin
        op_q  <= op_code;
        cnt_q <= '0;
        acc_q <= '0;
        x_q   <= a;
        y_q   <= b;
      end
      if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_nxt;
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        if (cnt_q == CNT_LAST) begin
          result <= mc_res;
          zero   <= (mc_res == '0);
          ovf    <= 1'b0;
          err    <= div0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op_code = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, ovf, err;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_code(op_code), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // dly: edges between the accept edge and the edge after which out_valid
  // is first seen (0 for single-cycle ops, W for mul/div); -1 skips the check
  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         z, o, e;
    int           dly;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z, o, e;
    int           dly;
    int           acc_edge;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_output: got result %h with no pending op", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.res);
        chk("flags_zero_ovf_err", {zero, ovf, err}, {mon_e.z, mon_e.o, mon_e.e});
        if (mon_e.dly >= 0)
          chk("latency", W'(cyc - mon_e.acc_edge), W'(mon_e.dly));
      end
    end
  end

  task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [3:0] vop,
                         input logic [W-1:0] vres, input logic vz, input logic vo,
                         input logic ve, input int vdly);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.res = vres;
    v.z = vz; v.o = vo; v.e = ve; v.dly = vdly;
    vecs.push_back(v);
  endtask

  // Called at posedge+#1; returns at posedge+#1 of the accept edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] top,
                      input logic [W-1:0] eres, input logic ez, input logic eo,
                      input logic ee, input int edly);
    exp_t e;
    int g;
    a = ta; b = tb_v; op_code = top; in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: op %0d in_ready %b, required 1", top, in_ready);
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    e.res = eres; e.z = ez; e.o = eo; e.e = ee; e.dly = edly;
    e.acc_edge = cyc + 1;
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op_code = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic stale;

    add_vec(32'h7FFF_FFFF, 32'd1,         4'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
    add_vec(32'd5,         32'd5,         4'd1,  32'h0,         1'b1, 1'b0, 1'b0, 0);
    add_vec(32'h8000_0000, 32'h21,        4'd4,  32'h0,         1'b1, 1'b0, 1'b0, 0);
    add_vec(32'h8000_0000, 32'h21,        4'd5,  32'h4000_0000, 1'b0, 1'b0, 1'b0, 0);
    add_vec(32'h8000_0000, 32'h21,        4'd6,  32'hC000_0000, 1'b0, 1'b0, 1'b0, 0);
    add_vec(32'hF0F0_1234, 32'h0FF0_FFFF, 4'd2,  32'h00F0_1234, 1'b0, 1'b0, 1'b0, 0);
    add_vec(32'hF000_0000, 32'h0000_000F, 4'd3,  32'hF000_000F, 1'b0, 1'b0, 1'b0, 0);
    add_vec(32'd5,         32'hFFFF_FFFF, 4'd7,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    add_vec(32'd5,         32'hFFFF_FFFF, 4'd8,  32'd5,         1'b0, 1'b0, 1'b0, 0);
    add_vec(32'hFFFF_FFFF, 32'd1,         4'd9,  32'd1,         1'b0, 1'b0, 1'b0, 0);
    add_vec(32'd1,         32'hFFFF_FFFF, 4'd9,  32'd0,         1'b1, 1'b0, 1'b0, 0);
    add_vec(32'h8000_0000, 32'd1,         4'd1,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    add_vec(32'h8000_0000, 32'h8000_0000, 4'd0,  32'h0,         1'b1, 1'b1, 1'b0, 0);
    add_vec(32'd0,         32'd1,         4'd1,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    add_vec(32'd3,         32'd4,         4'd13, 32'h0,         1'b1, 1'b0, 1'b1, 0);
    add_vec(32'd3,         32'd4,         4'd15, 32'h0,         1'b1, 1'b0, 1'b1, 0);
    add_vec(32'h1234,      32'd3,         4'd5,  32'h246,       1'b0, 1'b0, 1'b0, 0);
`ifdef SEQ_ALU_MULDIV_EN
    add_vec(32'd7,         32'd6,         4'd10, 32'd42,        1'b0, 1'b0, 1'b0, W);
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'd1,         1'b0, 1'b0, 1'b0, W);
    add_vec(32'd100,       32'd7,         4'd11, 32'd14,        1'b0, 1'b0, 1'b0, W);
    add_vec(32'd100,       32'd7,         4'd12, 32'd2,         1'b0, 1'b0, 1'b0, W);
    add_vec(32'd9,         32'd0,         4'd11, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, W);
    add_vec(32'd9,         32'd0,         4'd12, 32'd9,         1'b0, 1'b0, 1'b1, W);
    add_vec(32'hFFFF_FFFF, 32'h10,        4'd11, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, W);
    add_vec(32'd48,        32'd6,         4'd12, 32'd0,         1'b1, 1'b0, 1'b0, W);
`else
    add_vec(32'd7,         32'd6,         4'd10, 32'h0,         1'b1, 1'b0, 1'b1, 0);
    add_vec(32'd100,       32'd7,         4'd11, 32'h0,         1'b1, 1'b0, 1'b1, 0);
    add_vec(32'd100,       32'd7,         4'd12, 32'h0,         1'b1, 1'b0, 1'b1, 0);
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_result", result, '0);
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_flags", {zero, ovf, err}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Table vectors, back to back with out_ready high
    foreach (vecs[i])
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].e, vecs[i].dly);
    drain();

    // Backpressure: result must hold while out_ready is low
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'd3, 32'd4, 4'd0, 32'd7, 1'b0, 1'b0, 1'b0, -1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", result, 32'd7);
      chk("hold_in_ready_valid", {in_ready, out_valid}, W'(2'b01));
    end
    @(posedge clk);
    #1;
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(W'(i), 32'd100, 4'd0, W'(i + 100), 1'b0, 1'b0, 1'b0, 0);
    drain();
    chk("burst_count", W'(pop_cyc.size()), W'(9));
    if (pop_cyc.size() == 9)
      chk("burst_span", W'(pop_cyc[8] - pop_cyc[0]), W'(8));
    chk("idle_out_valid", W'(out_valid), '0);
    chk("idle_result_holds", result, 32'd107);
    chk("idle_in_ready", W'(in_ready), W'(1));

    // Reset while a result is pending in DONE
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'd1, 32'd2, 4'd0, 32'd3, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("done_pending_result", result, 32'd3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_done_out_valid", W'(out_valid), '0);
    chk("rst_done_result", result, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_done_in_ready", W'(in_ready), W'(1));
    chk("rst_done_out_valid_after", W'(out_valid), '0);

`ifdef SEQ_ALU_MULDIV_EN
    // Reset in the middle of a multiply: no stale result may appear
    @(posedge clk);
    #1;
    send(32'd7, 32'd6, 4'd10, 32'd42, 1'b0, 1'b0, 1'b0, W);
    @(negedge clk);
    chk("busy_in_ready_valid", {in_ready, out_valid}, '0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mul_out_valid", W'(out_valid), '0);
    chk("rst_mul_result", result, '0);
    chk("rst_mul_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("rst_mul_no_stale", W'(stale), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the datapath ALU. It is registered and WIDTH-generic, with an operand/result valid-ready interface. Single-cycle logic/arith/shift ops complete in one cycle. Multiply and unsigned divide/remainder are iterative multi-cycle operations. It sits in the EX stage between the operand mux and the writeback/branch logic. It keeps the existing 4-bit op encoding and extends it.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of 2
- SH_W, $clog2(WIDTH), shift-amount bits taken from b (derived, not overridden)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- a  in  WIDTH  operand A (read_data1 side)
- b  in  WIDTH  operand B (mux output)
- op_code  in  4  operation select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- ovf  out  1  signed overflow (add/sub only)
- err  out  1  illegal op or divide-by-zero

## Operation
- op 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra (shift by b[SH_W-1:0])
- op 7 max unsigned, 8 min unsigned, 9 slt signed (result 1/0)
- op 10 mul: low WIDTH bits of a*b, shift-add, one bit per cycle
- op 11 divu quotient, op 12 remu remainder: restoring division, one bit per cycle
- ops 13–15 are illegal: result 0, err=1, zero=1, single-cycle latency
- Divide by zero (b==0, op 11/12): quotient all ones, remainder = a, err=1. Full WIDTH-cycle latency is kept.
- ovf: add sets it when sign(a)==sign(b)≠sign(sum); sub sets it when sign(a)≠sign(b) and sign(diff)≠sign(a); 0 for all other ops
- zero is computed on the final result for every op
- Arithmetic wraps modulo 2^WIDTH; no carry-out port
- FSM states:
  - IDLE: in_ready=1; a single-cycle op goes to DONE, an op 10–12 goes to BUSY
  - BUSY: counter runs 0..WIDTH-1; leave to DONE when the counter reaches WIDTH-1
  - DONE: out_valid=1; on out_ready, go to IDLE, or accept the next op in the same cycle (see Timing)
- Operands are captured at accept; a/b/op_code changes afterwards have no effect

## Timing
- Reset (async, any state, including mid-BUSY):
  - state IDLE, counter 0
  - result 0, zero 0, ovf 0, err 0, out_valid 0
  - in_ready 1 from the first edge after rst_n deasserts
  - any partial operation is discarded
- in_ready = (IDLE) || (DONE && out_ready); combinational from state and out_ready only
- Single-cycle op accepted at edge k: out_valid=1 and result stable after edge k (latency 1)
- Op 10–12 accepted at edge k: BUSY during edges k+1..k+WIDTH-1; out_valid=1 after edge k+WIDTH (latency WIDTH)
- out_valid and all result/flag outputs hold stable while out_ready=0
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the old result retires and the new op is accepted on the same edge. Single-cycle ops therefore sustain 1 result/cycle.
- In DONE with out_ready=1 and in_valid=0: go to IDLE; out_valid=0 next cycle; result holds its value

## Configuration
- SEQ_ALU_MULDIV_EN defined: ops 10–12 are implemented as above; BUSY state and counter are present
- Not defined: ops 10–12 are treated as illegal (result 0, err=1, latency 1); no BUSY state, counter or shift-add/divider datapath is synthesised

## Test plan
- Reset mid-mul: WIDTH=32, accept op 10, assert rst_n=0 at cycle 5 -> out_valid=0, result=0, in_ready=1 after release; no stale result appears
- Add overflow: a=0x7FFFFFFF, b=1, op 0 -> result 0x80000000, ovf=1, zero=0, out_valid 1 cycle after accept; sub a=5, b=5 -> result 0, zero=1
- Shifts: a=0x80000000, b=0x21 (shift 1), ops 4/5/6 -> 0x00000000 (zero=1) / 0x40000000 / 0xC0000000
- Mul/div (macro on): a=7, b=6, op 10 -> 42 exactly 32 cycles after accept; a=100, b=7, ops 11/12 -> 14 and 2; a=9, b=0, op 11 -> 0xFFFFFFFF, err=1; op 12 -> 9, err=1
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles -> result stable, in_ready=0; then out_ready=1 and in_valid=1 every cycle with 8 add ops -> 8 results on 8 consecutive cycles
- Macro off, WIDTH=16: op 10 -> result 0, err=1, latency 1; op 9 with a=0xFFFF, b=1 -> result 1
